// File: rtl/regbank_arb_pkg.sv
// Shared types and widths for the register-bank arbiter.
package regbank_arb_pkg;

    localparam int unsigned REG_SEL_W = 3;
    localparam int unsigned DATA_W    = 8;

    // Transaction sequencer states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        PTR   = 3'd2,
        WRITE = 3'd3,
        ACK   = 3'd4
    } state_e;

    // Request fields latched at grant time
    typedef struct packed {
        logic                 we;
        logic                 ind;
        logic [REG_SEL_W-1:0] sel;
        logic [DATA_W-1:0]    wdata;
    } req_fields_t;

    // Owner encoding for the one-bit owner and priority pointer
    localparam logic OWNER_A = 1'b0;
    localparam logic OWNER_B = 1'b1;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way combinational arbiter; ptr picks the winner when both request.
module rr_arbiter_2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt_c
);

    // One-hot grant: bit 0 = requester A, bit 1 = requester B
    always_comb begin
        gnt_c = 2'b00;
        if (req == 2'b11) begin
            gnt_c = ptr ? 2'b10 : 2'b01;
        end else begin
            gnt_c = req;
        end
    end

endmodule

// File: rtl/register_bank_arbiter.sv
// Arbitrates two requesters onto a single register bank; supports direct and
// indirect reads and writes, all outputs registered.
module register_bank_arbiter
    import regbank_arb_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 a_req,
    input  logic                 a_we,
    input  logic                 a_ind,
    input  logic [REG_SEL_W-1:0] a_sel,
    input  logic [DATA_W-1:0]    a_wdata,
    output logic                 a_ack,
    output logic [DATA_W-1:0]    a_rdata,
    input  logic                 b_req,
    input  logic                 b_we,
    input  logic                 b_ind,
    input  logic [REG_SEL_W-1:0] b_sel,
    input  logic [DATA_W-1:0]    b_wdata,
    output logic                 b_ack,
    output logic [DATA_W-1:0]    b_rdata,
    output logic                 busy,
    output logic                 bank_read_en,
    output logic                 bank_write_en,
    output logic [REG_SEL_W-1:0] bank_rx_sel,
    output logic [REG_SEL_W-1:0] bank_ry_sel,
    output logic                 bank_indirect_en,
    output logic [DATA_W-1:0]    bank_wdata,
    input  logic [DATA_W-1:0]    bank_bus_data,
    input  logic [DATA_W-1:0]    bank_ry_data
);

    state_e               state_q, state_d;
    logic                 ptr_q, ptr_d;
    logic                 owner_q, owner_d;
    req_fields_t          fld_q, fld_d;
    logic [REG_SEL_W-1:0] tgt_q, tgt_d;

    logic                 a_ack_q, a_ack_d;
    logic                 b_ack_q, b_ack_d;
    logic [DATA_W-1:0]    a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0]    b_rdata_q, b_rdata_d;
    logic                 busy_q, busy_d;
    logic                 rd_en_q, rd_en_d;
    logic                 wr_en_q, wr_en_d;
    logic [REG_SEL_W-1:0] rx_sel_q, rx_sel_d;
    logic [REG_SEL_W-1:0] ry_sel_q, ry_sel_d;
    logic                 ind_en_q, ind_en_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;

    logic [1:0]           gnt_c;
    req_fields_t          a_fld_c, b_fld_c;
    logic                 unused_ry_hi_c;

    assign a_fld_c = '{we: a_we, ind: a_ind, sel: a_sel, wdata: a_wdata};
    assign b_fld_c = '{we: b_we, ind: b_ind, sel: b_sel, wdata: b_wdata};

    // Only the low selector bits of the pointer register are meaningful
    assign unused_ry_hi_c = |bank_ry_data[DATA_W-1:REG_SEL_W];

    rr_arbiter_2 u_arb (
        .req   ({b_req, a_req}),
        .ptr   (ptr_q),
        .gnt_c (gnt_c)
    );

    // Next-state, latched fields, and next values of the registered outputs
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        fld_d     = fld_q;
        tgt_d     = tgt_q;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
        a_ack_d   = 1'b0;
        b_ack_d   = 1'b0;
        busy_d    = 1'b0;
        rd_en_d   = 1'b0;
        wr_en_d   = 1'b0;
        rx_sel_d  = '0;
        ry_sel_d  = '0;
        ind_en_d  = 1'b0;
        wdata_d   = '0;

        unique case (state_q)
            IDLE: begin
                if (gnt_c != 2'b00) begin
                    owner_d = gnt_c[1] ? OWNER_B : OWNER_A;
                    fld_d   = gnt_c[1] ? b_fld_c : a_fld_c;
                    tgt_d   = fld_d.sel;
                    if (!fld_d.we) begin
                        state_d = READ;
                    end else if (fld_d.ind) begin
                        state_d = PTR;
                    end else begin
                        state_d = WRITE;
                    end
                end
            end
            READ: begin
                if (owner_q == OWNER_B) begin
                    b_rdata_d = bank_bus_data;
                end else begin
                    a_rdata_d = bank_bus_data;
                end
                state_d = ACK;
            end
            PTR: begin
                tgt_d   = bank_ry_data[REG_SEL_W-1:0];
                state_d = WRITE;
            end
            WRITE: begin
                state_d = ACK;
            end
            ACK: begin
                ptr_d   = ~owner_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered, so they are decoded from the state being entered
        busy_d = (state_d != IDLE);
        unique case (state_d)
            READ: begin
                rd_en_d  = 1'b1;
                ry_sel_d = fld_d.sel;
                ind_en_d = fld_d.ind;
            end
            PTR: begin
                ry_sel_d = fld_d.sel;
            end
            WRITE: begin
                wr_en_d  = 1'b1;
                rx_sel_d = tgt_d;
                wdata_d  = fld_d.wdata;
            end
            ACK: begin
                a_ack_d = (owner_d == OWNER_A);
                b_ack_d = (owner_d == OWNER_B);
            end
            default: begin
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= OWNER_A;
            owner_q   <= OWNER_A;
            fld_q     <= '0;
            tgt_q     <= '0;
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
            busy_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            rx_sel_q  <= '0;
            ry_sel_q  <= '0;
            ind_en_q  <= 1'b0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            fld_q     <= fld_d;
            tgt_q     <= tgt_d;
            a_ack_q   <= a_ack_d;
            b_ack_q   <= b_ack_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
            busy_q    <= busy_d;
            rd_en_q   <= rd_en_d;
            wr_en_q   <= wr_en_d;
            rx_sel_q  <= rx_sel_d;
            ry_sel_q  <= ry_sel_d;
            ind_en_q  <= ind_en_d;
            wdata_q   <= wdata_d;
        end
    end

    assign a_ack            = a_ack_q;
    assign b_ack            = b_ack_q;
    assign a_rdata          = a_rdata_q;
    assign b_rdata          = b_rdata_q;
    assign busy             = busy_q;
    assign bank_read_en     = rd_en_q;
    assign bank_write_en    = wr_en_q;
    assign bank_rx_sel      = rx_sel_q;
    assign bank_ry_sel      = ry_sel_q;
    assign bank_indirect_en = ind_en_q;
    assign bank_wdata       = wdata_q;

endmodule

// File: tb/tb_register_bank_arbiter.sv
// Directed bench for register_bank_arbiter with a small register-bank model.
module tb_register_bank_arbiter;

    logic       clk;
    logic       rst_n;
    logic       a_req, a_we, a_ind;
    logic [2:0] a_sel;
    logic [7:0] a_wdata;
    logic       a_ack;
    logic [7:0] a_rdata;
    logic       b_req, b_we, b_ind;
    logic [2:0] b_sel;
    logic [7:0] b_wdata;
    logic       b_ack;
    logic [7:0] b_rdata;
    logic       busy;
    logic       bank_read_en, bank_write_en, bank_indirect_en;
    logic [2:0] bank_rx_sel, bank_ry_sel;
    logic [7:0] bank_wdata, bank_bus_data, bank_ry_data;

    // Bank model controls
    logic       bank_clr;
    logic       pre_en;
    logic [2:0] pre_sel;
    logic [7:0] pre_val;
    logic [7:0] regs [8];

    int chk_cnt  = 0;
    int pass_cnt = 0;

    register_bank_arbiter dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .a_req            (a_req),
        .a_we             (a_we),
        .a_ind            (a_ind),
        .a_sel            (a_sel),
        .a_wdata          (a_wdata),
        .a_ack            (a_ack),
        .a_rdata          (a_rdata),
        .b_req            (b_req),
        .b_we             (b_we),
        .b_ind            (b_ind),
        .b_sel            (b_sel),
        .b_wdata          (b_wdata),
        .b_ack            (b_ack),
        .b_rdata          (b_rdata),
        .busy             (busy),
        .bank_read_en     (bank_read_en),
        .bank_write_en    (bank_write_en),
        .bank_rx_sel      (bank_rx_sel),
        .bank_ry_sel      (bank_ry_sel),
        .bank_indirect_en (bank_indirect_en),
        .bank_wdata       (bank_wdata),
        .bank_bus_data    (bank_bus_data),
        .bank_ry_data     (bank_ry_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register bank: ry read port, bus read with optional indirection, one write port
    assign bank_ry_data  = regs[bank_ry_sel];
    assign bank_bus_data = bank_indirect_en ? regs[regs[bank_ry_sel][2:0]] : regs[bank_ry_sel];

    always @(posedge clk) begin
        if (bank_clr) begin
            for (int i = 0; i < 8; i++) regs[i] <= 8'h00;
        end else if (pre_en) begin
            regs[pre_sel] <= pre_val;
        end else if (bank_write_en) begin
            regs[bank_rx_sel] <= bank_wdata;
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic preload(input logic [2:0] sel, input logic [7:0] val);
        pre_en  = 1'b1;
        pre_sel = sel;
        pre_val = val;
        step();
        pre_en  = 1'b0;
    endtask

    task automatic set_a(input logic req, input logic we, input logic ind,
                         input logic [2:0] sel, input logic [7:0] wd);
        a_req = req; a_we = we; a_ind = ind; a_sel = sel; a_wdata = wd;
    endtask

    task automatic set_b(input logic req, input logic we, input logic ind,
                         input logic [2:0] sel, input logic [7:0] wd);
        b_req = req; b_we = we; b_ind = ind; b_sel = sel; b_wdata = wd;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bank_clr = 1'b1; pre_en = 1'b0; pre_sel = 3'd0; pre_val = 8'h00;
        set_a(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
        set_b(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
        step();
        step();
        bank_clr = 1'b0;
        chk_cnt++;
        if ({busy, a_ack, b_ack, bank_read_en, bank_write_en, bank_indirect_en} !== 6'b0)
            $display("FAIL reset_ctrl: got %b want 000000",
                     {busy, a_ack, b_ack, bank_read_en, bank_write_en, bank_indirect_en});
        else pass_cnt++;
        chk_cnt++;
        if ({bank_rx_sel, bank_ry_sel, bank_wdata} !== 14'h0)
            $display("FAIL reset_bus: got %h want 0", {bank_rx_sel, bank_ry_sel, bank_wdata});
        else pass_cnt++;
        chk_cnt++;
        if ({a_rdata, b_rdata} !== 16'h0)
            $display("FAIL reset_rdata: got %h want 0000", {a_rdata, b_rdata});
        else pass_cnt++;
        rst_n = 1'b1;
        step();
        chk_cnt++;
        if (busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", busy);
        else pass_cnt++;
    endtask

    task automatic test_direct_write_read();
        set_a(1'b1, 1'b1, 1'b0, 3'd3, 8'h5A);
        step();
        chk_cnt++;
        if ({bank_write_en, bank_rx_sel, bank_wdata, a_ack, busy} !== {1'b1, 3'd3, 8'h5A, 1'b0, 1'b1})
            $display("FAIL wr_cycle: got we=%b rx=%0d wd=%h ack=%b busy=%b want 1 3 5a 0 1",
                     bank_write_en, bank_rx_sel, bank_wdata, a_ack, busy);
        else pass_cnt++;
        step();
        chk_cnt++;
        if ({a_ack, b_ack, bank_write_en, regs[3]} !== {1'b1, 1'b0, 1'b0, 8'h5A})
            $display("FAIL wr_ack: got ack=%b/%b we=%b r3=%h want 1/0 0 5a",
                     a_ack, b_ack, bank_write_en, regs[3]);
        else pass_cnt++;
        set_a(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
        step();
        chk_cnt++;
        if ({a_ack, busy} !== 2'b00) $display("FAIL wr_done: got ack=%b busy=%b want 0 0", a_ack, busy);
        else pass_cnt++;

        set_a(1'b1, 1'b0, 1'b0, 3'd3, 8'h00);
        step();
        chk_cnt++;
        if ({bank_read_en, bank_ry_sel, bank_indirect_en, bank_write_en} !== {1'b1, 3'd3, 1'b0, 1'b0})
            $display("FAIL rd_cycle: got re=%b ry=%0d ind=%b we=%b want 1 3 0 0",
                     bank_read_en, bank_ry_sel, bank_indirect_en, bank_write_en);
        else pass_cnt++;
        step();
        chk_cnt++;
        if ({a_ack, a_rdata, bank_read_en} !== {1'b1, 8'h5A, 1'b0})
            $display("FAIL rd_ack: got ack=%b rdata=%h re=%b want 1 5a 0", a_ack, a_rdata, bank_read_en);
        else pass_cnt++;
        set_a(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
        step();
    endtask

    task automatic test_indirect_write();
        preload(3'd1, 8'hFC);
        set_a(1'b1, 1'b1, 1'b1, 3'd1, 8'h11);
        step();
        chk_cnt++;
        if ({busy, bank_ry_sel, bank_write_en, bank_read_en} !== {1'b1, 3'd1, 1'b0, 1'b0})
            $display("FAIL ptr_cycle: got busy=%b ry=%0d we=%b re=%b want 1 1 0 0",
                     busy, bank_ry_sel, bank_write_en, bank_read_en);
        else pass_cnt++;
        step();
        chk_cnt++;
        if ({bank_write_en, bank_rx_sel, bank_wdata, a_ack} !== {1'b1, 3'd4, 8'h11, 1'b0})
            $display("FAIL iwr_cycle: got we=%b rx=%0d wd=%h ack=%b want 1 4 11 0",
                     bank_write_en, bank_rx_sel, bank_wdata, a_ack);
        else pass_cnt++;
        step();
        chk_cnt++;
        if ({a_ack, regs[4], bank_write_en} !== {1'b1, 8'h11, 1'b0})
            $display("FAIL iwr_ack: got ack=%b r4=%h we=%b want 1 11 0", a_ack, regs[4], bank_write_en);
        else pass_cnt++;
        set_a(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
        step();
    endtask

    task automatic test_indirect_read();
        preload(3'd2, 8'h06);
        preload(3'd6, 8'h77);
        set_b(1'b1, 1'b0, 1'b1, 3'd2, 8'h00);
        step();
        chk_cnt++;
        if ({bank_read_en, bank_indirect_en, bank_ry_sel} !== {1'b1, 1'b1, 3'd2})
            $display("FAIL ird_cycle: got re=%b ind=%b ry=%0d want 1 1 2",
                     bank_read_en, bank_indirect_en, bank_ry_sel);
        else pass_cnt++;
        step();
        chk_cnt++;
        if ({b_ack, a_ack, b_rdata, a_rdata} !== {1'b1, 1'b0, 8'h77, 8'h5A})
            $display("FAIL ird_ack: got b_ack=%b a_ack=%b b_rd=%h a_rd=%h want 1 0 77 5a",
                     b_ack, a_ack, b_rdata, a_rdata);
        else pass_cnt++;
        set_b(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
        step();
        chk_cnt++;
        if ({bank_indirect_en, b_ack, busy} !== 3'b000)
            $display("FAIL ird_done: got ind=%b ack=%b busy=%b want 0 0 0", bank_indirect_en, b_ack, busy);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic exp_b;
        set_a(1'b1, 1'b0, 1'b0, 3'd3, 8'h00);
        set_b(1'b1, 1'b0, 1'b0, 3'd4, 8'h00);
        for (int k = 0; k < 4; k++) begin
            exp_b = k[0];
            step();
            chk_cnt++;
            if ({busy, bank_read_en, bank_ry_sel} !== {1'b1, 1'b1, exp_b ? 3'd4 : 3'd3})
                $display("FAIL arb_grant%0d: got busy=%b re=%b ry=%0d want 1 1 %0d",
                         k, busy, bank_read_en, bank_ry_sel, exp_b ? 4 : 3);
            else pass_cnt++;
            step();
            chk_cnt++;
            if ({a_ack, b_ack} !== {~exp_b, exp_b})
                $display("FAIL arb_ack%0d: got a=%b b=%b want %b %b", k, a_ack, b_ack, ~exp_b, exp_b);
            else pass_cnt++;
            step();
            chk_cnt++;
            if ({busy, a_ack, b_ack} !== 3'b000)
                $display("FAIL arb_idle%0d: got busy=%b a=%b b=%b want 0 0 0", k, busy, a_ack, b_ack);
            else pass_cnt++;
        end
        chk_cnt++;
        if ({a_rdata, b_rdata} !== {8'h5A, 8'h11})
            $display("FAIL arb_rdata: got %h/%h want 5a/11", a_rdata, b_rdata);
        else pass_cnt++;
        set_a(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
        set_b(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
        step();
    endtask

    task automatic test_req_drop();
        int ack_cnt;
        ack_cnt = 0;
        set_a(1'b1, 1'b0, 1'b0, 3'd4, 8'h00);
        step();
        set_a(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
        for (int k = 0; k < 4; k++) begin
            if (k == 0) begin
                chk_cnt++;
                if ({bank_read_en, bank_ry_sel} !== {1'b1, 3'd4})
                    $display("FAIL drop_read: got re=%b ry=%0d want 1 4", bank_read_en, bank_ry_sel);
                else pass_cnt++;
            end
            if (a_ack === 1'b1) ack_cnt++;
            step();
        end
        chk_cnt++;
        if ({ack_cnt, a_rdata} !== {32'd1, 8'h11})
            $display("FAIL drop_ack: got acks=%0d rdata=%h want 1 11", ack_cnt, a_rdata);
        else pass_cnt++;
    endtask

    task automatic test_reset_abort();
        preload(3'd5, 8'h00);
        set_a(1'b1, 1'b1, 1'b0, 3'd5, 8'h99);
        step();
        chk_cnt++;
        if (bank_write_en !== 1'b1) $display("FAIL abort_pre: got we=%b want 1", bank_write_en);
        else pass_cnt++;
        rst_n = 1'b0;
        set_a(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
        step();
        chk_cnt++;
        if ({bank_write_en, a_ack, b_ack, busy, bank_rx_sel, bank_wdata, a_rdata, b_rdata} !== 30'h0)
            $display("FAIL abort_outs: got we=%b ack=%b/%b busy=%b rx=%0d wd=%h rd=%h/%h want all 0",
                     bank_write_en, a_ack, b_ack, busy, bank_rx_sel, bank_wdata, a_rdata, b_rdata);
        else pass_cnt++;
        rst_n = 1'b1;
        set_a(1'b1, 1'b0, 1'b0, 3'd3, 8'h00);
        set_b(1'b1, 1'b0, 1'b0, 3'd4, 8'h00);
        step();
        chk_cnt++;
        if ({a_ack, b_ack, bank_ry_sel} !== {1'b0, 1'b0, 3'd3})
            $display("FAIL abort_grant: got ack=%b/%b ry=%0d want 0/0 3", a_ack, b_ack, bank_ry_sel);
        else pass_cnt++;
        step();
        chk_cnt++;
        if ({a_ack, b_ack, a_rdata} !== {1'b1, 1'b0, 8'h5A})
            $display("FAIL abort_next: got ack=%b/%b rdata=%h want 1/0 5a", a_ack, b_ack, a_rdata);
        else pass_cnt++;
        set_a(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
        set_b(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
        step();
    endtask

    initial begin
        test_reset();
        test_direct_write_read();
        test_indirect_write();
        test_indirect_read();
        test_back_to_back();
        test_req_drop();
        test_reset_abort();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/register_bank_arbiter.md
REGISTER_BANK_ARBITER -- requirements
Module: register_bank_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clk and rst_n.
REQ-002 The ports SHALL be, in this order:
- clk  in  1  system clock; all state on the rising edge
- rst_n  in  1  synchronous active-low reset
- a_req  in  1  requester A (control unit) access request
- a_we  in  1  A: 1 = write, 0 = read
- a_ind  in  1  A: indirect addressing
- a_sel  in  3  A: register selector
- a_wdata  in  8  A: write data
- a_ack  out  1  A: transaction complete, one-cycle pulse
- a_rdata  out  8  A: read result
- b_req, b_we, b_ind, b_sel, b_wdata, b_ack, b_rdata: same as A, for requester B (debug/IO port)
- busy  out  1  transaction in progress
- bank_read_en  out  1  bank bus-read enable
- bank_write_en  out  1  bank write enable
- bank_rx_sel  out  3  bank write / rx selector
- bank_ry_sel  out  3  bank read / ry selector
- bank_indirect_en  out  1  bank indirect-read mode
- bank_wdata  out  8  bank write data
- bank_bus_data  in  8  bank bus read data
- bank_ry_data  in  8  bank ry data (pointer source)

Function
REQ-003 FSM states SHALL be IDLE, READ, PTR, WRITE, ACK.
REQ-004 In IDLE with any req high, the block SHALL grant one requester, latch its we/ind/sel/wdata, and go to READ (we=0), WRITE (we=1, ind=0) or PTR (we=1, ind=1).
REQ-005 With both reqs high, the grant SHALL go to the requester named by a one-bit priority pointer; the pointer SHALL point to A after reset and to the non-granted requester after each ACK.
REQ-006 READ SHALL drive bank_read_en=1, bank_ry_sel=sel and bank_indirect_en=ind, capture bank_bus_data into the granted requester's rdata register at the end of the cycle, then go to ACK.
REQ-007 PTR SHALL drive bank_ry_sel=sel, latch bank_ry_data[2:0] as the target selector (bits 7:3 ignored), then go to WRITE.
REQ-008 WRITE SHALL drive bank_write_en=1, bank_rx_sel=target (sel if direct) and bank_wdata=wdata for exactly one cycle, then go to ACK.
REQ-009 ACK SHALL pulse the granted requester's ack for one cycle and return to IDLE; the other requester's ack SHALL stay 0.
REQ-010 Latency from the req-sampling edge to ack high: read 2 cycles; direct write 2 cycles; indirect write 3 cycles.
REQ-011 A requester SHALL hold req and its fields stable until ack; the block SHALL use only the values latched at grant, and a req dropped after grant SHALL still complete.
REQ-012 A req still high during ACK SHALL be ignored in that cycle and arbitrated in the following IDLE cycle, so there is at least 1 IDLE cycle between transactions.
REQ-013 Outside their own states, bank_read_en, bank_write_en and bank_indirect_en SHALL be 0, and sel/wdata outputs SHALL be 0.
REQ-014 a_rdata/b_rdata SHALL hold their last captured value until that requester's next read completes.
REQ-015 busy SHALL be 1 in every state except IDLE.

Reset
REQ-016 While rst_n=0 at a clock edge, the FSM SHALL go to IDLE, the pointer to A, and all outputs and rdata registers to 0; a transaction in progress is aborted with no write and no ack.

Structure
REQ-017 The shared package regbank_arb_pkg SHALL hold the state enum, REG_SEL_W=3 and DATA_W=8.
REQ-018 The grant logic SHALL be the sub-module rr_arbiter_2: two requests and a pointer in, a one-hot grant out, combinational.

Verification
REQ-019 The bench SHALL cover these scenarios:
- A writes 0x5A to r3, then reads r3 -> bank_write_en for 1 cycle with rx_sel=3; a_ack 2 cycles after each req; a_rdata=0x5A.
- r2=0x06, r6=0x77; B indirect-reads sel=2 -> bank_indirect_en=1 in READ; b_rdata=0x77.
- r1=0xFC; A indirect-writes 0x11 via sel=1 -> PTR then WRITE with rx_sel=4; r4=0x11; ack 3 cycles after req.
- a_req and b_req held high, 4 transactions -> grants A,B,A,B; one IDLE cycle between them.
- rst_n low during WRITE -> no write_en in the next cycle, no ack, all outputs 0, next grant goes to A.
- a_req dropped the cycle after grant -> transaction still completes and a_ack pulses once.
